// File: rtl/hub75_capture.sv
// HUB75 receive monitor: accumulates per-pixel RGB on-counts into a bus-readable RAM (HUB75_CAPTURE_IRQ_EN adds irq).
// Bus read data valid one cycle after accept; ready drops while the update engine holds the RAM read port.
module hub75_capture #(
    parameter int          ROWS          = 64,
    parameter int          COLS          = 64,
    parameter logic [31:0] BASEADDR      = 32'h8110_0000,
    parameter int          WINDOW_FRAMES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               addr,
    input  logic [31:0]               wdata,
    input  logic [3:0]                wmask,
    input  logic                      wen,
    input  logic                      ren,
    output logic [31:0]               rdata,
    output logic                      ready,
    output logic                      active,
    input  logic                      R0,
    input  logic                      G0,
    input  logic                      B0,
    input  logic                      R1,
    input  logic                      G1,
    input  logic                      B1,
    input  logic [$clog2(ROWS/2)-1:0] ROWSEL,
    input  logic                      CLK_HUB75,
    input  logic                      LATCH,
`ifdef HUB75_CAPTURE_IRQ_EN
    output logic                      irq,
`endif
    input  logic                      OE
);
    localparam int AB  = $clog2(ROWS/2);
    localparam int CW  = $clog2(COLS);
    localparam int CLW = $clog2(COLS+1);
    localparam int NW  = ROWS*COLS;
    localparam int AW  = $clog2(NW);
    localparam int EW  = $clog2(2*COLS+2);
    localparam int SW  = 9 + AB;
    localparam logic [AB-1:0] LAST_ROW   = AB'(ROWS/2 - 1);
    localparam logic [31:0]   TOP_ADDR   = BASEADDR + 32'(4*(NW+1));
    localparam logic [EW-1:0] ENG_RD_END = EW'(2*COLS);
    localparam logic [EW-1:0] ENG_LAST   = EW'(2*COLS+1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_SYNC  = 3'd2;
    localparam logic [2:0] S_ACCUM = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [SW-1:0] pins, sync1, sync2;
    logic          clk3, latch3;
    assign pins = {R0, G0, B0, R1, G1, B1, ROWSEL, CLK_HUB75, LATCH, OE};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            clk3   <= 1'b0;
            latch3 <= 1'b0;
        end else begin
            sync1  <= pins;
            sync2  <= sync1;
            clk3   <= sync2[2];
            latch3 <= sync2[1];
        end
    end

    logic [5:0]    s_bits;
    logic [AB-1:0] s_row;
    logic          s_oe, clk_rise, latch_rise;
    assign s_bits     = sync2[SW-1 -: 6];
    assign s_row      = sync2[3 +: AB];
    assign s_oe       = sync2[0];
    assign clk_rise   = sync2[2] & ~clk3;
    assign latch_rise = sync2[1] & ~latch3;

    logic [2:0]            state;
    logic [COLS-1:0][5:0]  line_q, hold_q;
    logic [AB-1:0]         hold_row;
    logic [CLW-1:0]        col;
    logic                  eng_busy;
    logic [EW-1:0]         eng_n;
    logic                  ovf_evt, ovr_evt, eng_go, eng_last;

    assign ovf_evt  = clk_rise && !latch_rise && (col == CLW'(COLS));
    assign eng_go   = latch_rise && !eng_busy && (state == S_ACCUM);
    assign ovr_evt  = latch_rise && eng_busy && (state == S_ACCUM);
    assign eng_last = eng_busy && (eng_n == ENG_LAST);

    // A latch arriving while the engine runs must not disturb the line it is working on.
    always_ff @(posedge clk) begin
        if (rst) begin
            col      <= '0;
            line_q   <= '0;
            hold_q   <= '0;
            hold_row <= '0;
        end else begin
            if (latch_rise) begin
                col <= '0;
                if (!eng_busy) begin
                    hold_q   <= line_q;
                    hold_row <= s_row;
                end
            end else if (clk_rise && (col != CLW'(COLS))) begin
                line_q[col[CW-1:0]] <= s_bits;
                col                 <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            eng_busy <= 1'b0;
            eng_n    <= '0;
        end else if (eng_go) begin
            eng_busy <= 1'b1;
            eng_n    <= '0;
        end else if (eng_busy) begin
            eng_busy <= !eng_last;
            eng_n    <= eng_n + 1'b1;
        end
    end

    logic          eng_rd, eng_half;
    logic [CW-1:0] eng_col;
    logic [5:0]    eng_px;
    logic [2:0]    eng_bits;
    logic [AW-1:0] eng_addr;
    assign eng_rd   = eng_busy && (eng_n < ENG_RD_END);
    assign eng_half = eng_n[CW];
    assign eng_col  = eng_n[CW-1:0];
    assign eng_px   = hold_q[eng_col];
    assign eng_bits = eng_half ? eng_px[2:0] : eng_px[5:3];
    assign eng_addr = {eng_half, hold_row, eng_col};

    logic          p_vld;
    logic [AW-1:0] p_addr;
    logic [2:0]    p_bits;
    always_ff @(posedge clk) begin
        if (rst) begin
            p_vld  <= 1'b0;
            p_addr <= '0;
            p_bits <= '0;
        end else begin
            p_vld  <= eng_rd;
            p_addr <= eng_addr;
            p_bits <= eng_bits;
        end
    end

    function automatic logic [7:0] sat_inc(input logic [7:0] c, input logic b);
        return (b && (c != 8'hFF)) ? c + 8'd1 : c;
    endfunction

    logic [23:0]   mem [NW];
    logic [23:0]   mem_q, upd, wdat;
    logic [AW-1:0] clr_idx, waddr, raddr, mem_idx;
    logic          we, re;
    assign upd   = {sat_inc(mem_q[23:16], p_bits[0]), sat_inc(mem_q[15:8], p_bits[1]),
                    sat_inc(mem_q[7:0], p_bits[2])};
    assign we    = (state == S_CLEAR) || p_vld;
    assign waddr = (state == S_CLEAR) ? clr_idx : p_addr;
    assign wdat  = (state == S_CLEAR) ? 24'h0 : upd;

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdat;
        if (re)
            mem_q <= mem[raddr];
    end

    logic [31:0] off;
    logic [29:0] word;
    logic        is_csr, bus_rd_mem, csr_wr;
    assign off        = addr - BASEADDR;
    assign word       = off[31:2];
    assign active     = (addr >= BASEADDR) && (addr < TOP_ADDR);
    assign is_csr     = (word == 30'(NW));
    assign mem_idx    = word[AW-1:0];
    assign bus_rd_mem = ren && active && !is_csr;
    assign ready      = active && !(bus_rd_mem && eng_rd);
    assign raddr      = eng_rd ? eng_addr : mem_idx;
    assign re         = eng_rd || bus_rd_mem;
    assign csr_wr     = wen && active && is_csr;

    logic       done_f, ovr_f, ovf_f, irq_en;
    logic [7:0] frame_cnt;
    logic [31:0] csr_val;
`ifdef HUB75_CAPTURE_IRQ_EN
    assign csr_val = {8'h0, frame_cnt, 7'h0, irq_en, 3'h0, ovf_f, ovr_f, done_f, state != S_IDLE, 1'b0};
    assign irq     = done_f & irq_en;
    logic unused_bits;
    assign unused_bits = ^{s_oe, off[1:0], wdata[31:9], wdata[7:5], wdata[1], wmask[3:2]};
`else
    assign csr_val = {16'h0, frame_cnt, 3'h0, ovf_f, ovr_f, done_f, state != S_IDLE, 1'b0};
    logic unused_bits;
    assign unused_bits = ^{s_oe, off[1:0], wdata[31:5], wdata[1], wmask[3:1], irq_en};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            clr_idx   <= '0;
            frame_cnt <= '0;
            done_f    <= 1'b0;
            ovr_f     <= 1'b0;
            ovf_f     <= 1'b0;
            irq_en    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (csr_wr && wmask[0] && wdata[0]) begin
                    state     <= S_CLEAR;
                    clr_idx   <= '0;
                    frame_cnt <= '0;
                end
                S_CLEAR: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == AW'(NW-1))
                        state <= S_SYNC;
                end
                S_SYNC: if (latch_rise && (s_row == LAST_ROW))
                    state <= S_ACCUM;
                S_ACCUM: if (eng_last && (hold_row == LAST_ROW)) begin
                    frame_cnt <= frame_cnt + 8'd1;
                    if (frame_cnt + 8'd1 == 8'(WINDOW_FRAMES))
                        state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
            if (state == S_DONE)                        done_f <= 1'b1;
            else if (csr_wr && wmask[0] && wdata[2])    done_f <= 1'b0;
            if (ovr_evt)                                ovr_f  <= 1'b1;
            else if (csr_wr && wmask[0] && wdata[3])    ovr_f  <= 1'b0;
            if (ovf_evt)                                ovf_f  <= 1'b1;
            else if (csr_wr && wmask[0] && wdata[4])    ovf_f  <= 1'b0;
`ifdef HUB75_CAPTURE_IRQ_EN
            if (csr_wr && wmask[1])                     irq_en <= wdata[8];
`endif
        end
    end

    logic        rd_mem;
    logic [31:0] rd_csr;
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_mem <= 1'b0;
            rd_csr <= '0;
        end else if (ren && active && ready) begin
            rd_mem <= !is_csr;
            if (is_csr)
                rd_csr <= csr_val;
        end
    end
    assign rdata = rd_mem ? {8'h0, mem_q} : rd_csr;
endmodule

// File: tb/tb_hub75_capture.sv
// Directed bench for hub75_capture with a 4x4 panel and a 2-frame capture window.
module tb_hub75_capture;
    localparam logic [31:0] BASE  = 32'h8110_0000;
    localparam logic [31:0] CSR_A = BASE + 32'h40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  wmask = '0;
    logic        wen = 1'b0, ren = 1'b0;
    logic [31:0] rdata;
    logic        ready, active;
    logic        R0 = 0, G0 = 0, B0 = 0, R1 = 0, G1 = 0, B1 = 0;
    logic [0:0]  ROWSEL = '0;
    logic        CLK_HUB75 = 0, LATCH = 0, OE = 1;
`ifdef HUB75_CAPTURE_IRQ_EN
    logic        irq;
`endif
    int          checks = 0;
    int          errors = 0;
    logic [31:0] rd;

    always #5 clk = ~clk;

    hub75_capture #(.ROWS(4), .COLS(4), .BASEADDR(BASE), .WINDOW_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wmask(wmask), .wen(wen), .ren(ren),
        .rdata(rdata), .ready(ready), .active(active),
        .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1),
        .ROWSEL(ROWSEL), .CLK_HUB75(CLK_HUB75), .LATCH(LATCH),
`ifdef HUB75_CAPTURE_IRQ_EN
        .irq(irq),
`endif
        .OE(OE)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        int tries;
        @(negedge clk);
        addr = a;
        ren  = 1'b1;
        #1;
        tries = 0;
        while (!ready && tries < 40) begin
            @(negedge clk);
            #1;
            tries++;
        end
        check("rd_accept", {31'b0, ready}, 32'd1);
        @(negedge clk);
        ren = 1'b0;
        d   = rdata;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        wmask = 4'hF;
        wen   = 1'b1;
        @(negedge clk);
        wen   = 1'b0;
    endtask

    task automatic check_word(input string tag, input int idx, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(BASE + 32'(idx * 4), d);
        check(tag, d, exp);
    endtask

    task automatic check_csr(input string tag, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(CSR_A, d);
        check(tag, d, exp);
    endtask

    task automatic hub_clk(input logic [5:0] b);
        @(negedge clk);
        {R0, G0, B0, R1, G1, B1} = b;
        CLK_HUB75 = 1'b0;
        repeat (2) @(negedge clk);
        CLK_HUB75 = 1'b1;
        repeat (2) @(negedge clk);
        CLK_HUB75 = 1'b0;
    endtask

    task automatic shift_uniform(input logic [5:0] b);
        for (int c = 0; c < 4; c++) hub_clk(b);
    endtask

    task automatic hub_latch(input logic r);
        @(negedge clk);
        ROWSEL = r;
        repeat (2) @(negedge clk);
        LATCH = 1'b1;
        repeat (2) @(negedge clk);
        LATCH = 1'b0;
        repeat (16) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rdata_rst", rdata, 32'h0);
        addr = CSR_A;        #1; check("active_csr", {31'b0, active}, 32'd1);
        addr = CSR_A + 4;    #1; check("active_above", {31'b0, active}, 32'd0);
        addr = BASE - 4;     #1; check("active_below", {31'b0, active}, 32'd0);
        check_csr("csr_rst", 32'h0);

        // Clear then an all-ones capture window.
        bus_write(CSR_A, 32'h1);
        check_csr("csr_clearing", 32'h2);
        repeat (20) @(negedge clk);
        check_word("word5_cleared", 5, 32'h0);
        hub_latch(1'b1);
        shift_uniform(6'b111111); hub_latch(1'b0);
        shift_uniform(6'b111111); hub_latch(1'b1);
        check_csr("csr_frame1", 32'h102);
        shift_uniform(6'b111111); hub_latch(1'b0);
        shift_uniform(6'b111111); hub_latch(1'b1);
        check_csr("csr_done", 32'h204);
        check_word("ones_w0", 0, 32'h020202);
        check_word("ones_w5", 5, 32'h020202);
        check_word("ones_w15", 15, 32'h020202);
        bus_write(CSR_A, 32'h4);
        check_csr("csr_done_clr", 32'h200);

        // Extra shift clock beyond the line width is dropped.
        bus_write(CSR_A, 32'h1);
        repeat (20) @(negedge clk);
        hub_latch(1'b1);
        for (int f = 0; f < 2; f++) begin
            shift_uniform(6'b100000); hub_clk(6'b111111); hub_latch(1'b0);
            shift_uniform(6'b000001); hub_latch(1'b1);
        end
        check_csr("csr_ovf", 32'h214);
        check_word("ovf_w0", 0, 32'h000002);
        check_word("ovf_w3", 3, 32'h000002);
        check_word("ovf_w8", 8, 32'h0);
        check_word("ovf_w6", 6, 32'h0);
        check_word("ovf_w12", 12, 32'h020000);

        // Back-to-back latches: second one dropped.
        bus_write(CSR_A, 32'h1C);
        check_csr("csr_flags_clr", 32'h200);
        bus_write(CSR_A, 32'h1);
        repeat (20) @(negedge clk);
        hub_latch(1'b1);
        shift_uniform(6'b010000);
        @(negedge clk); ROWSEL = 1'b0;
        repeat (2) @(negedge clk);
        LATCH = 1'b1; @(negedge clk);
        LATCH = 1'b0; @(negedge clk);
        LATCH = 1'b1; @(negedge clk);
        LATCH = 1'b0;
        repeat (16) @(negedge clk);
        shift_uniform(6'b000000); hub_latch(1'b1);
        check_csr("csr_overrun", 32'h10A);
        check_word("ovr_w0", 0, 32'h000100);
        check_word("ovr_w3", 3, 32'h000100);
        check_word("ovr_w4", 4, 32'h0);
        bus_write(CSR_A, 32'h1);
        check_csr("start_ignored", 32'h10A);
        check_word("start_ignored_w0", 0, 32'h000100);
        hub_latch(1'b1);
        check_csr("csr_ovr_done", 32'h20C);

        // Saturation: row 0 latched 300 times across the window.
        bus_write(CSR_A, 32'h1C);
        bus_write(CSR_A, 32'h1);
        repeat (20) @(negedge clk);
        hub_latch(1'b1);
        hub_clk(6'b000000); hub_clk(6'b000000); hub_clk(6'b100000); hub_clk(6'b000000);
        for (int i = 0; i < 200; i++) hub_latch(1'b0);
        hub_latch(1'b1);
        check_csr("csr_sat_f1", 32'h102);
        check_word("sat_w2_200", 2, 32'h0000C8);
        check_word("sat_w6_1", 6, 32'h000001);
        for (int i = 0; i < 100; i++) hub_latch(1'b0);
        hub_latch(1'b1);
        check_csr("csr_sat_done", 32'h204);
        check_word("sat_w2", 2, 32'h0000FF);
        check_word("sat_w6_2", 6, 32'h000002);
        check_word("sat_w3", 3, 32'h0);
        check_word("sat_w10", 10, 32'h0);

        // Reset clears control state but not captured memory.
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rdata_rst2", rdata, 32'h0);
        check_csr("csr_rst2", 32'h0);
        check_word("mem_kept", 2, 32'h0000FF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
